// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencing controller.
package mac_ctrl_pkg;

   localparam int N_DEF     = 4;
   localparam int KW_DEF    = 8;
   localparam int CLEAR_CYC = 1;
   localparam int PIPE_LAT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/skew_mask.sv
// Diagonal operand-valid mask: edge lane r carries element cnt-r while 0 <= cnt-r < k.
module skew_mask #(
   parameter int N  = 4,
   parameter int KW = 8,
   parameter int CW = KW + 5
) (
   input  logic [CW-1:0] cnt,
   input  logic [KW-1:0] k,
   output logic [N-1:0]  mask
);

   always_comb begin
      mask = '0;
      for (int r = 0; r < N; r++) begin
         mask[r] = (cnt >= CW'(r)) && (cnt < CW'(r) + CW'(k));
      end
   end

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for an N x N systolic MAC array: clear, skewed operand feed, pipeline drain, done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; accumulators hold last result
// ST_CLEAR | one cycle of mac_clr, captured K decides FEED or DONE
// ST_FEED  | feed_cnt steps 0..K+N-2, skewed edge operands valid
// ST_DRAIN | N+1 cycles flushing tile skew and load->mult->acc pipeline
// ST_DONE  | one-cycle done pulse
module mac_array_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int KW = KW_DEF,
   parameter int CW = KW + 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   output logic          busy,
   output logic          done,
   output logic          mac_clr,
   output logic          load_en,
   output logic          mult_en,
   output logic          acc_en,
   output logic [CW-1:0] feed_cnt,
   output logic [N-1:0]  a_valid,
   output logic [N-1:0]  b_valid
);

   localparam int DW = $clog2(N + 1);

   state_t        state, state_nxt;
   logic [KW-1:0] k_reg, k_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [DW-1:0] tmr, tmr_nxt;
   logic [CW-1:0] feed_last;
   logic [N-1:0]  mask_raw;
   logic [N-1:0]  mask_nxt;
   logic          en_nxt;

   assign feed_last = CW'(k_reg) + CW'(N - 2);

   always_comb begin
      state_nxt = state;
      k_nxt     = k_reg;
      cnt_nxt   = feed_cnt;
      tmr_nxt   = tmr;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CLEAR;
               k_nxt     = k_len;
            end
         end
         ST_CLEAR: begin
            cnt_nxt   = '0;
            state_nxt = (k_reg != '0) ? ST_FEED : ST_DONE;
         end
         ST_FEED: begin
            if (feed_cnt == feed_last) begin
               state_nxt = ST_DRAIN;
               // down-count N..0 gives skew (N-1) plus pipeline latency cycles
               tmr_nxt   = DW'(N + PIPE_LAT - 2);
            end else begin
               cnt_nxt = feed_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (tmr == '0) state_nxt = ST_DONE;
            else           tmr_nxt   = tmr - 1'b1;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   skew_mask #(.N(N), .KW(KW), .CW(CW)) u_skew_mask (
      .cnt  (cnt_nxt),
      .k    (k_nxt),
      .mask (mask_raw)
   );

   assign mask_nxt = (state_nxt == ST_FEED) ? mask_raw : '0;
   assign en_nxt   = (state_nxt == ST_FEED) || (state_nxt == ST_DRAIN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         k_reg    <= '0;
         feed_cnt <= '0;
         tmr      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mac_clr  <= 1'b0;
         load_en  <= 1'b0;
         mult_en  <= 1'b0;
         acc_en   <= 1'b0;
         a_valid  <= '0;
         b_valid  <= '0;
      end else begin
         state    <= state_nxt;
         k_reg    <= k_nxt;
         feed_cnt <= cnt_nxt;
         tmr      <= tmr_nxt;
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_DONE);
         mac_clr  <= (state_nxt == ST_CLEAR);
         load_en  <= en_nxt;
         mult_en  <= en_nxt;
         acc_en   <= en_nxt;
         a_valid  <= mask_nxt;
         b_valid  <= mask_nxt;
      end
   end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: pass-schedule model, attached systolic MAC array, directed and random passes.
module tb_mac_array_ctrl;

   localparam int N  = 4;
   localparam int KW = 8;
   localparam int CW = KW + 5;
   localparam int KMAX = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy, done, mac_clr, load_en, mult_en, acc_en;
   logic [CW-1:0] feed_cnt;
   logic [N-1:0]  a_valid, b_valid;

   int checks   = 0;
   int failures = 0;

   int m_pos = 0;
   int m_k   = 0;

   int amat [N][KMAX];
   int bmat [KMAX][N];
   int ea [N];
   int eb [N];
   int ar [N][N];
   int br [N][N];
   int pr [N][N];
   int acc [N][N];

   int clr_h [41];
   int en_h  [41];
   int done_h[41];
   int busy_h[41];
   int cnt_h [41];
   int av_h  [41];
   int a00_h [41];
   int a03_h [41];

   always #5 clk = ~clk;

   mac_array_ctrl #(.N(N), .KW(KW), .CW(CW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .k_len    (k_len),
      .busy     (busy),
      .done     (done),
      .mac_clr  (mac_clr),
      .load_en  (load_en),
      .mult_en  (mult_en),
      .acc_en   (acc_en),
      .feed_cnt (feed_cnt),
      .a_valid  (a_valid),
      .b_valid  (b_valid)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pass_last(input int k);
      return (k == 0) ? 2 : k + 2 * N + 2;
   endfunction

   function automatic int gold(input int i, input int j, input int k);
      int s = 0;
      for (int t = 0; t < k; t++) s += amat[i][t] * bmat[t][j];
      return s;
   endfunction

   // Pass schedule model: m_pos = cycles since acceptance (0 = idle).
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pos <= 0;
      end else if (m_pos == 0) begin
         if (start) begin
            m_pos <= 1;
            m_k   <= int'(k_len);
         end
      end else if (m_pos == pass_last(m_k)) begin
         m_pos <= 0;
      end else begin
         m_pos <= m_pos + 1;
      end
   end

   // Edge muxes and a behavioural systolic MAC array driven by the controller.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = int'(feed_cnt) - i;
         ea[i] = 0;
         eb[i] = 0;
         if (a_valid[i] && idx >= 0 && idx < KMAX) ea[i] = amat[i][idx];
         if (b_valid[i] && idx >= 0 && idx < KMAX) eb[i] = bmat[idx][i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (mac_clr) begin
               ar[i][j]  <= 0;
               br[i][j]  <= 0;
               pr[i][j]  <= 0;
               acc[i][j] <= 0;
            end else begin
               if (load_en) begin
                  if (j == 0) ar[i][j] <= ea[i];
                  else        ar[i][j] <= ar[i][j-1];
                  if (i == 0) br[i][j] <= eb[j];
                  else        br[i][j] <= br[i-1][j];
               end
               if (mult_en) pr[i][j]  <= ar[i][j] * br[i][j];
               if (acc_en)  acc[i][j] <= acc[i][j] + pr[i][j];
            end
         end
      end
   end

   // Per-cycle compare against the schedule model.
   always @(negedge clk) begin
      int p, kk, c;
      bit e_feed, e_drain, e_done, e_en;
      logic [N-1:0] e_mask;
      p  = reset_n ? m_pos : 0;
      kk = m_k;
      e_feed  = (kk > 0) && (p >= 2) && (p <= kk + N);
      e_drain = (kk > 0) && (p >= kk + N + 1) && (p <= kk + 2 * N + 1);
      e_done  = (p != 0) && (p == pass_last(kk));
      e_en    = e_feed || e_drain;
      e_mask  = '0;
      c = p - 2;
      if (e_feed) for (int r = 0; r < N; r++) if (c >= r && c < r + kk) e_mask[r] = 1'b1;
      check("busy", busy, p > 0);
      check("done", done, e_done);
      check("mac_clr", mac_clr, p == 1);
      check("load_en", load_en, e_en);
      check("mult_en", mult_en, e_en);
      check("acc_en", acc_en, e_en);
      check("a_valid", a_valid, e_mask);
      check("b_valid", b_valid, e_mask);
      if (e_feed) check("feed_cnt", feed_cnt, c);
      if (e_done) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               check($sformatf("acc_%0d_%0d", i, j), acc[i][j], gold(i, j, kk));
      end
   end

   task automatic observe(input int ncyc, input int drop_at);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         clr_h[c]  = mac_clr;
         en_h[c]   = load_en;
         done_h[c] = done;
         busy_h[c] = busy;
         cnt_h[c]  = int'(feed_cnt);
         av_h[c]   = int'(a_valid);
         a00_h[c]  = acc[0][0];
         a03_h[c]  = acc[0][3];
         if (c == drop_at) start = 1'b0;
      end
   endtask

   function automatic int first_of(input int which, input int ncyc);
      for (int c = 1; c <= ncyc; c++) begin
         if (which == 0 && clr_h[c] != 0) return c;
         if (which == 1 && en_h[c] != 0) return c;
         if (which == 2 && done_h[c] != 0) return c;
      end
      return -1;
   endfunction

   function automatic int count_of(input int which, input int ncyc);
      int n = 0;
      for (int c = 1; c <= ncyc; c++) begin
         if (which == 0 && clr_h[c] != 0) n++;
         if (which == 1 && en_h[c] != 0) n++;
         if (which == 2 && done_h[c] != 0) n++;
         if (which == 3 && busy_h[c] != 0) n++;
      end
      return n;
   endfunction

   function automatic int last_en(input int ncyc);
      int l = -1;
      for (int c = 1; c <= ncyc; c++) if (en_h[c] != 0) l = c;
      return l;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int guard;
      reset_n = 1'b0;
      start   = 1'b0;
      k_len   = '0;
      for (int i = 0; i < N; i++)
         for (int t = 0; t < KMAX; t++) begin
            amat[i][t] = (i == t) ? 2 : 1;
            bmat[t][i] = (i == t) ? 2 : 1;
         end
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_valid", a_valid, 0);
      #1 reset_n = 1'b1;

      // K=4 timing, skew masks and identity-plus-ones product
      @(negedge clk);
      k_len = 8'd4;
      start = 1'b1;
      observe(16, 1);
      check("k4_clr_cycle", first_of(0, 16), 1);
      check("k4_clr_count", count_of(0, 16), 1);
      check("k4_first_en", first_of(1, 16), 2);
      check("k4_last_en", last_en(16), 13);
      check("k4_done_cycle", first_of(2, 16), 14);
      check("k4_done_count", count_of(2, 16), 1);
      check("k4_busy_count", count_of(3, 16), 14);
      check("k4_busy_c1", busy_h[1], 1);
      check("k4_busy_c15", busy_h[15], 0);
      check("k4_cnt_c2", cnt_h[2], 0);
      check("k4_cnt_c8", cnt_h[8], 6);
      check("k4_av_cnt0", av_h[2], 4'b0001);
      check("k4_av_cnt3", av_h[5], 4'b1111);
      check("k4_av_cnt5", av_h[7], 4'b1100);
      check("k4_av_drain", av_h[9], 0);
      check("k4_acc00", a00_h[14], 7);
      check("k4_acc03", a03_h[14], 6);
      check("k4_acc00_hold", a00_h[16], 7);

      // K=0 goes CLEAR -> DONE with no enables
      k_len = 8'd0;
      start = 1'b1;
      observe(5, 1);
      check("k0_clr_cycle", first_of(0, 5), 1);
      check("k0_done_cycle", first_of(2, 5), 2);
      check("k0_en_count", count_of(1, 5), 0);
      check("k0_acc00", a00_h[2], 0);

      // start held high: back-to-back passes
      k_len = 8'd2;
      start = 1'b1;
      observe(26, 26);
      check("hold_done_count", count_of(2, 26), 2);
      check("hold_clr_count", count_of(0, 26), 2);
      check("hold_second_clr", clr_h[14], 1);
      check("hold_idle_c13", busy_h[13], 0);

      // reset during DRAIN aborts, then a K=3 pass
      k_len = 8'd5;
      start = 1'b1;
      observe(11, 1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", load_en, 0);
      check("rst_valid", a_valid, 0);
      check("rst_cnt", feed_cnt, 0);
      check("abort_done_count", count_of(2, 11), 0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      k_len = 8'd3;
      start = 1'b1;
      observe(16, 1);
      check("k3_done_cycle", first_of(2, 16), 13);
      check("k3_done_count", count_of(2, 16), 1);

      // random passes, random operands, start/k_len noise while busy
      for (int pass = 0; pass < 30; pass++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) begin
               amat[i][t] = int'($urandom_range(0, 15));
               bmat[t][i] = int'($urandom_range(0, 15));
            end
         k_len = KW'($urandom_range(0, 12));
         start = 1'b1;
         @(negedge clk);
         guard = 0;
         while (m_pos != 0 && guard < 200) begin
            start = 1'($urandom_range(0, 1));
            k_len = KW'($urandom);
            @(negedge clk);
            guard++;
         end
         start = 1'b0;
         check("pass_timeout", guard < 200, 1);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
